// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, MD_WAIT} state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = (inc_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for load-use, taken-branch and multi-cycle mul/div hazards
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_uses_rs2_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_addr_i,
  input  logic             id_branch_taken_i,
  input  logic             ex_md_valid_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_write_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_bubble_o,
  output logic             md_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int MC_W = $clog2(MD_LATENCY) + 1;
  localparam logic [MC_W-1:0] MD_INIT = MC_W'(MD_LATENCY > 1 ? MD_LATENCY - 2 : 0);
  state_e state_d, state_q;
  logic [MC_W-1:0] md_cnt_d, md_cnt_q;
  logic loaduse, freeze;
  assign loaduse = idex_memread_i && idex_rd_addr_i != REG_ZERO &&
                   (idex_rd_addr_i == id_rs1_addr_i || (id_uses_rs2_i && idex_rd_addr_i == id_rs2_addr_i));
  // the release cycle of MD_WAIT (md_cnt==0) falls through to the normal RUN hazard checks
  assign freeze = (state_q == RUN && ex_md_valid_i && MD_LATENCY > 1) ||
                  (state_q == MD_WAIT && md_cnt_q != '0);
  always_comb begin
    state_d         = state_q;
    md_cnt_d        = md_cnt_q;
    pc_write_o      = 1'b1;
    if_id_write_o   = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_write_o   = 1'b1;
    id_ex_bubble_o  = 1'b0;
    ex_mem_bubble_o = 1'b0;
    md_busy_o       = 1'b0;
    if (state_q == IDLE) begin
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      id_ex_bubble_o  = 1'b1;
      ex_mem_bubble_o = 1'b1;
      state_d         = start_i ? RUN : IDLE;
    end else if (freeze) begin
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      id_ex_write_o   = 1'b0;
      ex_mem_bubble_o = 1'b1;
      md_busy_o       = 1'b1;
      state_d         = MD_WAIT;
      md_cnt_d        = state_q == RUN ? MD_INIT : md_cnt_q - MC_W'(1);
    end else begin
      state_d = RUN;
      if (loaduse) begin
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        id_ex_bubble_o = 1'b1;
      end else begin
        if_id_flush_o = id_branch_taken_i;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q  <= IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (state_q != IDLE && !pc_write_o),
    .cnt_o (stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (if_id_flush_o),
    .cnt_o (flush_cnt_o)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl (MD_LATENCY=4, CNT_W=3)
module tb_pipe_hazard_ctrl;
  localparam int CW = 3;
  // output vector order: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, md_busy}
  localparam logic [6:0] O_IDLE = 7'b0001110;
  localparam logic [6:0] O_RUN  = 7'b1101000;
  localparam logic [6:0] O_LU   = 7'b0001100;
  localparam logic [6:0] O_BR   = 7'b1111000;
  localparam logic [6:0] O_MD   = 7'b0000011;
  typedef struct {
    logic [6:0]    outs;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;
  logic clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0;
  logic [4:0] id_rs1_addr_i = '0, id_rs2_addr_i = '0, idex_rd_addr_i = '0;
  logic id_uses_rs2_i = 1'b0, idex_memread_i = 1'b0, id_branch_taken_i = 1'b0, ex_md_valid_i = 1'b0;
  logic pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o, id_ex_bubble_o, ex_mem_bubble_o, md_busy_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;
  int checks = 0, errors = 0;
  logic [CW-1:0] m_stall = '0, m_flush = '0;
  exp_t sb[$];
  always #5 clk_i = ~clk_i;
  pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(CW)) dut (
    .clk_i (clk_i), .rst_i (rst_i), .start_i (start_i),
    .id_rs1_addr_i (id_rs1_addr_i), .id_rs2_addr_i (id_rs2_addr_i), .id_uses_rs2_i (id_uses_rs2_i),
    .idex_memread_i (idex_memread_i), .idex_rd_addr_i (idex_rd_addr_i),
    .id_branch_taken_i (id_branch_taken_i), .ex_md_valid_i (ex_md_valid_i),
    .pc_write_o (pc_write_o), .if_id_write_o (if_id_write_o), .if_id_flush_o (if_id_flush_o),
    .id_ex_write_o (id_ex_write_o), .id_ex_bubble_o (id_ex_bubble_o), .ex_mem_bubble_o (ex_mem_bubble_o),
    .md_busy_o (md_busy_o), .stall_cnt_o (stall_cnt_o), .flush_cnt_o (flush_cnt_o)
  );
  function automatic logic [6:0] outs();
    return {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o, id_ex_bubble_o, ex_mem_bubble_o, md_busy_o};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic st, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                      input logic br, input logic md, input logic run, input logic [6:0] eo);
    exp_t e;
    @(negedge clk_i);
    start_i = st; idex_memread_i = mr; idex_rd_addr_i = rd; id_rs1_addr_i = rs1;
    id_rs2_addr_i = rs2; id_uses_rs2_i = u2; id_branch_taken_i = br; ex_md_valid_i = md;
    if (run && !eo[6] && m_stall != '1) m_stall++;
    if (eo[4] && m_flush != '1) m_flush++;
    sb.push_back('{eo, m_stall, m_flush});
    #1;
    e = sb.pop_front();
    chk({tag, "_outs"}, 32'(outs()), 32'(e.outs));
    @(posedge clk_i);
    #1;
    chk({tag, "_stall"}, 32'(stall_cnt_o), 32'(e.stall));
    chk({tag, "_flush"}, 32'(flush_cnt_o), 32'(e.flush));
  endtask
  task automatic do_reset();
    rst_i = 1'b0;
    m_stall = '0;
    m_flush = '0;
    #1;
    chk("rst_outs", 32'(outs()), 32'(O_IDLE));
    chk("rst_stall", 32'(stall_cnt_o), 0);
    chk("rst_flush", 32'(flush_cnt_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask
  initial begin
    do_reset();
    step("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);
    step("start",     1, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);
    step("lu_rs1",    0, 1, 5, 5, 0, 0, 0, 0, 1, O_LU);
    step("after_lu",  0, 0, 0, 5, 0, 0, 0, 0, 1, O_RUN);
    step("rd0",       0, 1, 0, 0, 0, 0, 0, 0, 1, O_RUN);
    step("rs2_unused",0, 1, 7, 1, 7, 0, 0, 0, 1, O_RUN);
    step("lu_rs2",    0, 1, 7, 1, 7, 1, 0, 0, 1, O_LU);
    step("start_run", 1, 0, 0, 0, 0, 0, 0, 0, 1, O_RUN);
    step("br",        0, 0, 0, 0, 0, 0, 1, 0, 1, O_BR);
    step("br_lu",     0, 1, 3, 3, 0, 0, 1, 0, 1, O_LU);
    step("br_held",   0, 0, 0, 3, 0, 0, 1, 0, 1, O_BR);
    step("md1",       0, 0, 0, 0, 0, 0, 1, 1, 1, O_MD);
    step("md2",       0, 0, 0, 0, 0, 0, 1, 1, 1, O_MD);
    step("md3",       0, 0, 0, 0, 0, 0, 1, 1, 1, O_MD);
    step("md_rel",    0, 0, 0, 0, 0, 0, 1, 1, 1, O_BR);
    step("md_after",  0, 0, 0, 0, 0, 0, 0, 0, 1, O_RUN);
    @(negedge clk_i);
    do_reset();
    step("r_start",   1, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);
    step("r_md1",     0, 0, 0, 0, 0, 0, 0, 1, 1, O_MD);
    step("r_md2",     0, 0, 0, 0, 0, 0, 0, 1, 1, O_MD);
    @(negedge clk_i);
    do_reset();
    step("r_idle",    0, 0, 0, 0, 0, 0, 0, 1, 0, O_IDLE);
    step("r_start2",  1, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);
    step("r_run",     0, 0, 0, 0, 0, 0, 0, 0, 1, O_RUN);
    step("r_run2",    0, 0, 0, 0, 0, 0, 0, 0, 1, O_RUN);
    for (int i = 0; i < 10; i++)
      step("sat", 0, 1, 9, 9, 0, 0, 0, 0, 1, O_LU);
    chk("sat_final", 32'(stall_cnt_o), 7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives write enables and bubble inserts for PC, IF/ID, ID/EX and EX/MEM from three inputs: load-use hazards, taken branches resolved in ID, and a multi-cycle mul/div op occupying EX.
- Keeps saturating stall and flush performance counters.

Parameters:
- MD_LATENCY, 4: total cycles a mul/div op occupies EX. Must be >= 1; a value of 1 means no freeze.
- CNT_W, 32: width of the performance counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- start_i  in  1  pipeline run enable, sampled in IDLE.
- id_rs1_addr_i  in  5  rs1 of the instruction in ID.
- id_rs2_addr_i  in  5  rs2 of the instruction in ID.
- id_uses_rs2_i  in  1  instruction in ID reads rs2.
- idex_memread_i  in  1  MemRead of the instruction in EX (ID/EX output).
- idex_rd_addr_i  in  5  rd of the instruction in EX.
- id_branch_taken_i  in  1  branch resolved taken in ID this cycle.
- ex_md_valid_i  in  1  the instruction in EX is a mul/div.
- pc_write_o  out  1  PC update enable.
- if_id_write_o  out  1  IF/ID load enable.
- if_id_flush_o  out  1  zero IF/ID on the next edge.
- id_ex_write_o  out  1  ID/EX load enable (0 = hold).
- id_ex_bubble_o  out  1  force RegWrite/MemtoReg/MemRead/MemWrite to 0 into ID/EX.
- ex_mem_bubble_o  out  1  force control bits to 0 into EX/MEM.
- md_busy_o  out  1  EX frozen by mul/div.
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0 while not IDLE.
- flush_cnt_o  out  CNT_W  cycles with if_id_flush_o=1.

Behaviour:
- States: IDLE, RUN, MD_WAIT. Internal down-counter md_cnt is $clog2(MD_LATENCY)+1 bits.
- Outputs are combinational from state and inputs. Counters and md_cnt are registered.

Reset (rst_i=0), asynchronous:
- state=IDLE, md_cnt=0, both counters=0.

IDLE:
- pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1, ex_mem_bubble=1, flush=0, md_busy=0.
- start_i=1 moves to RUN on the next edge. IDLE cycles are not counted.

RUN terms:
- loaduse = idex_memread_i & (idex_rd_addr_i!=0) & ((rd==rs1) | (id_uses_rs2_i & rd==rs2)).
- mdstart = ex_md_valid_i & (MD_LATENCY>1).

RUN priority, highest first:
1. mdstart (freeze): pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1, md_busy=1, flush=0. md_cnt<=MD_LATENCY-2; go to MD_WAIT.
2. loaduse: pc_write=0, if_id_write=0, id_ex_bubble=1, flush=0 (the branch re-evaluates after the stall). Exactly 1 stall cycle per hazard.
3. id_branch_taken_i: if_id_flush=1, all writes=1. The flush is suppressed whenever 1 or 2 is active.
4. Otherwise: all writes=1, all bubbles/flush=0.

MD_WAIT:
- md_cnt!=0: freeze outputs as in RUN item 1, md_cnt--.
- md_cnt==0 (release cycle): evaluate exactly as RUN items 2-4, md_busy=0. Return to RUN.
- Total EX occupancy is MD_LATENCY cycles. Back-to-back mul/div re-enters the freeze on the next cycle.

start_i:
- Ignored outside IDLE. Only rst_i returns the block to IDLE.

Counters:
- Increment by 1 per qualifying cycle and saturate at 2^CNT_W-1 (no wrap).
- A cycle that is both stall and flush is impossible by construction.

Reset mid-MD_WAIT:
- Outputs take their IDLE values immediately (asynchronous).
- md_cnt is cleared; there is no residual freeze after release.

Decomposition:
- Package pipe_ctrl_pkg: state enum {IDLE, RUN, MD_WAIT} and a REG_ZERO=5'd0 constant.
- Sub-module sat_counter (parameter W; inc, clk, async active-low reset), instantiated twice for the counters.
- The load-use compare stays inline.

Test Plan:
- Load-use: reset, start_i=1; EX: lw x5 (memread=1, rd=5); ID: rs1=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle all writes=1; stall_cnt=1.
- rd=0 or rs2-only match with id_uses_rs2_i=0: rd=0/rs1=0, or rd=7/rs2=7/uses_rs2=0 -> no stall; stall_cnt unchanged.
- Branch: id_branch_taken_i=1, no hazard -> if_id_flush=1 for 1 cycle, flush_cnt=1. With loaduse simultaneously -> flush=0, stall=1; the branch is held 1 cycle then flushes (flush_cnt=1, stall_cnt=1).
- Mul/div, MD_LATENCY=4: ex_md_valid_i=1 -> md_busy=1 and id_ex_write=0 for 3 cycles, release on the 4th; stall_cnt=3. With a simultaneous taken branch, flush appears only on the release cycle.
- Reset mid-op: assert rst_i=0 during the 2nd MD_WAIT cycle -> outputs take IDLE values immediately; after deassert and start_i, the pipeline runs with md_busy=0 and counters=0.
- Saturation, CNT_W=3: hold loaduse for 10 cycles -> stall_cnt_o stops at 7.
